rvh_mmu_miss_arb: RTL and testbench
===================================

// Module: rvh_mmu_miss_arb
// PURPOSE
//  N-port TLB-miss front end for the shared PTW (ITLB, DTLB, L2TLB, prefetcher ports).
//  Round-robin arbitrates miss requests into one translate_req stream.
//  Records the source port of each accepted request in an in-order FIFO.
//  Routes each translate_resp back to its source port and sequences TLB-flush grants.
// PARAMETERS
//  NUM_PORTS       2   requester ports, >=2
//  MAX_INFLIGHT    2   max accepted-but-unanswered translations, >=1
//  TRANS_ID_WIDTH  3   per-port transaction id width
//  VPN_WIDTH       27  virtual page number width
//  PAGE_LVL_WIDTH  2   page level width
//  PORT_ID_WIDTH   local: NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1
// PORTS
//  clk                    in   1               clock
//  rst                    in   1               async reset, active-high
//  miss_req_vld_i         in   NUM_PORTS       per-port request valid
//  miss_req_trans_id_i    in   NUM_PORTS*TID   packed, port p at [p*W +: W]
//  miss_req_asid_i        in   NUM_PORTS*16    packed asid
//  miss_req_vpn_i         in   NUM_PORTS*VPN   packed vpn
//  miss_req_access_type_i in   NUM_PORTS*2     packed R=0/W=1/X=2
//  miss_req_rdy_o         out  NUM_PORTS       one-hot (or 0) accept
//  miss_resp_vld_o        out  NUM_PORTS       one-hot (or 0) response strobe
//  miss_resp_*_o          out  as PTW          trans_id/asid/pte[64]/page_lvl/vpn/access_type/access_fault/page_fault, broadcast
//  translate_req_vld_o    out  1               to PTW
//  translate_req_*_o      out  as above        muxed payload of granted port
//  translate_req_rdy_i    in   1               PTW accepts
//  translate_resp_vld_i   in   1               PTW result valid (always accepted)
//  translate_resp_*_i     in   as above        PTW result payload
//  tlb_flush_vld_i        in   1               flush request (level, held until grant)
//  tlb_flush_grant_o      out  1               1-cycle grant
//  perf_grant_cnt_o       out  NUM_PORTS*32    only with RVH_MMU_MISS_ARB_PERF_EN
//  perf_stall_cnt_o       out  32              only with RVH_MMU_MISS_ARB_PERF_EN
// BEHAVIOUR
//  Reset: all outputs 0; rr_ptr=NUM_PORTS-1; FIFO empty; state RUN; counters 0.
//  Arbitration (comb):
//   - Search starts at rr_ptr+1 mod NUM_PORTS; first valid port wins.
//   - translate_req_vld_o = state==RUN & |miss_req_vld_i & ~fifo_full.
//  Handshake: miss_req_rdy_o[g] = translate_req_vld_o & translate_req_rdy_i.
//   - On the handshake: push g into the FIFO and set rr_ptr<=g.
//   - rr_ptr holds when there is no handshake.
//   - Payload is stable only while the winner is unchanged; upstream holds vld until rdy.
//  Response: 0-cycle pass-through.
//   - miss_resp_vld_o[fifo_head] = translate_resp_vld_i; FIFO pops.
//   - Response with FIFO empty: no port strobed, FIFO unchanged, SVA flags error.
//   - fifo_full with same-cycle pop: full still blocks; no bypass.
//  FSM RUN -> DRAIN when tlb_flush_vld_i: no new grants (rdy all 0); responses still route.
//   - DRAIN with FIFO empty -> GRANT.
//   - GRANT drives tlb_flush_grant_o=1 for exactly 1 cycle -> RUN.
//   - flush_vld in RUN with FIFO already empty: RUN->DRAIN->GRANT, grant 2 cycles later.
//   - Flush dropped before grant: FSM still completes GRANT.
//  Reset mid-walk: FIFO is cleared; PTW is reset by the same rst.
//  Width rules: FIFO ptrs mod MAX_INFLIGHT with extra wrap bit; rr_ptr wraps NUM_PORTS-1 -> 0.
// CONFIGURATION
//  RVH_MMU_MISS_ARB_PERF_EN defined:
//   - perf_grant_cnt_o[p] increments on each port-p handshake.
//   - perf_stall_cnt_o increments in cycles with |miss_req_vld_i & no handshake.
//   - Both counters saturate at all-ones.
//  Undefined: perf ports and counters absent from the port list.
// STRUCTURE
//  rvh_mmu_pkg: access-type constants (R/W/X), ASID_WIDTH=16, PTE_WIDTH=64, FSM enum {RUN,DRAIN,GRANT}.
//  Sub-module rvh_mmu_rr_arb (NUM_PORTS): req, ptr -> one-hot gnt + index.
//  Source-port FIFO is inline.
// TESTING
//  1 NUM_PORTS=3; ports 0,2 vld, rdy=1 each cycle.
//    -> grants 0,2,0,2.
//    -> add port1 at cycle 2: sequence 0,2,0,1,2.
//  2 MAX_INFLIGHT=2; two accepts, no resp.
//    -> translate_req_vld_o=0 while req pending.
//    -> resp: miss_resp_vld_o one-hot to the first port, then the second.
//  3 Port1 trans_id=5 vpn=0x1234 accepted; resp trans_id=5.
//    -> miss_resp_vld_o=3'b010 same cycle, payload equal.
//  4 Flush with 1 inflight.
//    -> rdy=0 until resp; grant 1 cycle after the resp cycle.
//    -> grants resume the cycle after grant.
//  5 rst asserted mid-walk with 2 inflight.
//    -> all outputs 0 asynchronously; post-reset resp strobes no port.
//  6 PERF_EN; 10 port0 handshakes, 4 blocked cycles.
//    -> perf_grant_cnt_o[0]=10, perf_stall_cnt_o=4.

Source files
------------

// File: rtl/rvh_mmu_pkg.sv
// rvh_mmu_pkg: shared constants and types for the MMU miss front end.
// Access-type codes, ASID/PTE widths, flush FSM states, id-width helper.
package rvh_mmu_pkg;

  localparam int ASID_WIDTH = 16;
  localparam int PTE_WIDTH  = 64;

  localparam logic [1:0] ACC_R = 2'd0;
  localparam logic [1:0] ACC_W = 2'd1;
  localparam logic [1:0] ACC_X = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GRANT = 2'd2
  } arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rvh_mmu_rr_arb.sv
// rvh_mmu_rr_arb: round-robin picker, search starts at ptr+1 mod NUM_PORTS.
// Ports: req (per-port valid), ptr (last winner) -> gnt (one-hot or 0), idx.
module rvh_mmu_rr_arb
  import rvh_mmu_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int PW = id_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      j = (int'(ptr) + i) % NUM_PORTS;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rvh_mmu_miss_arb.sv
// rvh_mmu_miss_arb: N-port TLB-miss arbiter in front of the shared PTW.
// RR-grants miss requests into translate_req, tracks source ports in an
// in-order FIFO, routes translate_resp back (0-cycle), sequences flush grants.
// Ports: miss_req_* (packed per port), miss_resp_* (one-hot vld, broadcast
// payload), translate_req_*/translate_resp_* (PTW side), tlb_flush_vld_i /
// tlb_flush_grant_o. Perf counters (perf_grant_cnt_o, perf_stall_cnt_o) exist
// only when RVH_MMU_MISS_ARB_PERF_EN is defined.
module rvh_mmu_miss_arb
  import rvh_mmu_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int MAX_INFLIGHT   = 2,
  parameter int TRANS_ID_WIDTH = 3,
  parameter int VPN_WIDTH      = 27,
  parameter int PAGE_LVL_WIDTH = 2,
  localparam int PORT_ID_WIDTH = id_width(NUM_PORTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                miss_req_vld_i,
  input  logic [NUM_PORTS*TRANS_ID_WIDTH-1:0] miss_req_trans_id_i,
  input  logic [NUM_PORTS*ASID_WIDTH-1:0]     miss_req_asid_i,
  input  logic [NUM_PORTS*VPN_WIDTH-1:0]      miss_req_vpn_i,
  input  logic [NUM_PORTS*2-1:0]              miss_req_access_type_i,
  output logic [NUM_PORTS-1:0]                miss_req_rdy_o,
  output logic [NUM_PORTS-1:0]                miss_resp_vld_o,
  output logic [TRANS_ID_WIDTH-1:0]           miss_resp_trans_id_o,
  output logic [ASID_WIDTH-1:0]               miss_resp_asid_o,
  output logic [PTE_WIDTH-1:0]                miss_resp_pte_o,
  output logic [PAGE_LVL_WIDTH-1:0]           miss_resp_page_lvl_o,
  output logic [VPN_WIDTH-1:0]                miss_resp_vpn_o,
  output logic [1:0]                          miss_resp_access_type_o,
  output logic                                miss_resp_access_fault_o,
  output logic                                miss_resp_page_fault_o,
  output logic                                translate_req_vld_o,
  output logic [TRANS_ID_WIDTH-1:0]           translate_req_trans_id_o,
  output logic [ASID_WIDTH-1:0]               translate_req_asid_o,
  output logic [VPN_WIDTH-1:0]                translate_req_vpn_o,
  output logic [1:0]                          translate_req_access_type_o,
  input  logic                                translate_req_rdy_i,
  input  logic                                translate_resp_vld_i,
  input  logic [TRANS_ID_WIDTH-1:0]           translate_resp_trans_id_i,
  input  logic [ASID_WIDTH-1:0]               translate_resp_asid_i,
  input  logic [PTE_WIDTH-1:0]                translate_resp_pte_i,
  input  logic [PAGE_LVL_WIDTH-1:0]           translate_resp_page_lvl_i,
  input  logic [VPN_WIDTH-1:0]                translate_resp_vpn_i,
  input  logic [1:0]                          translate_resp_access_type_i,
  input  logic                                translate_resp_access_fault_i,
  input  logic                                translate_resp_page_fault_i,
  input  logic                                tlb_flush_vld_i,
  output logic                                tlb_flush_grant_o
`ifdef RVH_MMU_MISS_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]             perf_grant_cnt_o,
  output logic [31:0]                         perf_stall_cnt_o
`endif
);

  localparam int PW = PORT_ID_WIDTH;
  localparam int AW = id_width(MAX_INFLIGHT);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PORTS - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(MAX_INFLIGHT - 1);

  arb_state_e state_q, state_d;

  logic [PW-1:0]        rr_ptr_q;
  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        gnt_idx;
  logic [NUM_PORTS-1:0] sel;

  logic [PW-1:0] src_q [MAX_INFLIGHT];
  logic [AW-1:0] wr_idx_q, rd_idx_q;
  logic          wr_wrap_q, rd_wrap_q;
  logic [AW-1:0] wr_idx_nxt, rd_idx_nxt;
  logic          wr_wrap_nxt, rd_wrap_nxt;
  logic          fifo_empty, fifo_full;
  logic          empty_after;
  logic [PW-1:0] head;

  logic hs;
  logic pop;

  rvh_mmu_rr_arb #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_arb (
    .req(miss_req_vld_i),
    .ptr(rr_ptr_q),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  // Extra wrap bit tells full from empty when indices match.
  assign fifo_empty = (wr_idx_q == rd_idx_q) &&
                      (wr_wrap_q == rd_wrap_q);
  assign fifo_full  = (wr_idx_q == rd_idx_q) &&
                      (wr_wrap_q != rd_wrap_q);

  assign wr_idx_nxt  = (wr_idx_q == IDX_LAST) ? '0 :
                       wr_idx_q + AW'(1);
  assign wr_wrap_nxt = wr_wrap_q ^ (wr_idx_q == IDX_LAST);
  assign rd_idx_nxt  = (rd_idx_q == IDX_LAST) ? '0 :
                       rd_idx_q + AW'(1);
  assign rd_wrap_nxt = rd_wrap_q ^ (rd_idx_q == IDX_LAST);

  assign head = src_q[rd_idx_q];

  // Full blocks even when a pop lands in the same cycle.
  assign translate_req_vld_o = !rst &&
                               (state_q == ST_RUN) &&
                               (|miss_req_vld_i) &&
                               !fifo_full;
  assign hs  = translate_req_vld_o && translate_req_rdy_i;
  assign pop = !rst && translate_resp_vld_i && !fifo_empty;

  assign miss_req_rdy_o = gnt & {NUM_PORTS{hs}};
  assign sel = gnt & {NUM_PORTS{translate_req_vld_o}};

  always_comb begin
    translate_req_trans_id_o    = '0;
    translate_req_asid_o        = '0;
    translate_req_vpn_o         = '0;
    translate_req_access_type_o = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      translate_req_trans_id_o = translate_req_trans_id_o |
        (miss_req_trans_id_i[p*TRANS_ID_WIDTH +: TRANS_ID_WIDTH] &
         {TRANS_ID_WIDTH{sel[p]}});
      translate_req_asid_o = translate_req_asid_o |
        (miss_req_asid_i[p*ASID_WIDTH +: ASID_WIDTH] &
         {ASID_WIDTH{sel[p]}});
      translate_req_vpn_o = translate_req_vpn_o |
        (miss_req_vpn_i[p*VPN_WIDTH +: VPN_WIDTH] &
         {VPN_WIDTH{sel[p]}});
      translate_req_access_type_o = translate_req_access_type_o |
        (miss_req_access_type_i[p*2 +: 2] & {2{sel[p]}});
    end
  end

  always_comb begin
    miss_resp_vld_o = '0;
    if (pop) miss_resp_vld_o[head] = 1'b1;
  end

  assign miss_resp_trans_id_o     = rst ? '0 : translate_resp_trans_id_i;
  assign miss_resp_asid_o         = rst ? '0 : translate_resp_asid_i;
  assign miss_resp_pte_o          = rst ? '0 : translate_resp_pte_i;
  assign miss_resp_page_lvl_o     = rst ? '0 : translate_resp_page_lvl_i;
  assign miss_resp_vpn_o          = rst ? '0 : translate_resp_vpn_i;
  assign miss_resp_access_type_o  = rst ? '0 : translate_resp_access_type_i;
  assign miss_resp_access_fault_o = !rst && translate_resp_access_fault_i;
  assign miss_resp_page_fault_o   = !rst && translate_resp_page_fault_i;

  // No pushes outside RUN, so this is the occupancy after this cycle's pop.
  assign empty_after = pop ?
    ({wr_wrap_q, wr_idx_q} == {rd_wrap_nxt, rd_idx_nxt}) :
    fifo_empty;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (tlb_flush_vld_i) state_d = ST_DRAIN;
      ST_DRAIN: if (empty_after) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign tlb_flush_grant_o = (state_q == ST_GRANT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      rr_ptr_q  <= PTR_LAST;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_wrap_q <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) src_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        rr_ptr_q        <= gnt_idx;
        src_q[wr_idx_q] <= gnt_idx;
        wr_idx_q        <= wr_idx_nxt;
        wr_wrap_q       <= wr_wrap_nxt;
      end
      if (pop) begin
        rd_idx_q  <= rd_idx_nxt;
        rd_wrap_q <= rd_wrap_nxt;
      end
    end
  end

`ifdef RVH_MMU_MISS_ARB_PERF_EN
  logic [31:0] grant_cnt_q [NUM_PORTS];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) grant_cnt_q[p] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (miss_req_rdy_o[p] && (grant_cnt_q[p] != '1))
          grant_cnt_q[p] <= grant_cnt_q[p] + 32'd1;
      end
      if ((|miss_req_vld_i) && !hs && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  always_comb begin
    perf_grant_cnt_o = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      perf_grant_cnt_o[p*32 +: 32] = grant_cnt_q[p];
  end
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

  // A response with nothing outstanding has no port to go to.
  resp_has_owner: assert property (
    @(posedge clk) disable iff (rst)
    translate_resp_vld_i |-> !fifo_empty
  ) else $warning("rvh_mmu_miss_arb: translate_resp with no outstanding request");

endmodule

// File: tb/tb_rvh_mmu_miss_arb.sv
// tb_rvh_mmu_miss_arb: directed vectors for rvh_mmu_miss_arb.
// 3 ports, 2 in flight; perf vectors only with RVH_MMU_MISS_ARB_PERF_EN.
module tb_rvh_mmu_miss_arb;
  import rvh_mmu_pkg::*;

  localparam int NP = 3;
  localparam int MI = 2;
  localparam int TW = 3;
  localparam int VW = 27;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     miss_req_vld_i;
  logic [NP*TW-1:0]  miss_req_trans_id_i;
  logic [NP*16-1:0]  miss_req_asid_i;
  logic [NP*VW-1:0]  miss_req_vpn_i;
  logic [NP*2-1:0]   miss_req_access_type_i;
  logic [NP-1:0]     miss_req_rdy_o;
  logic [NP-1:0]     miss_resp_vld_o;
  logic [TW-1:0]     miss_resp_trans_id_o;
  logic [15:0]       miss_resp_asid_o;
  logic [63:0]       miss_resp_pte_o;
  logic [LW-1:0]     miss_resp_page_lvl_o;
  logic [VW-1:0]     miss_resp_vpn_o;
  logic [1:0]        miss_resp_access_type_o;
  logic              miss_resp_access_fault_o;
  logic              miss_resp_page_fault_o;
  logic              translate_req_vld_o;
  logic [TW-1:0]     translate_req_trans_id_o;
  logic [15:0]       translate_req_asid_o;
  logic [VW-1:0]     translate_req_vpn_o;
  logic [1:0]        translate_req_access_type_o;
  logic              translate_req_rdy_i;
  logic              translate_resp_vld_i;
  logic [TW-1:0]     translate_resp_trans_id_i;
  logic [15:0]       translate_resp_asid_i;
  logic [63:0]       translate_resp_pte_i;
  logic [LW-1:0]     translate_resp_page_lvl_i;
  logic [VW-1:0]     translate_resp_vpn_i;
  logic [1:0]        translate_resp_access_type_i;
  logic              translate_resp_access_fault_i;
  logic              translate_resp_page_fault_i;
  logic              tlb_flush_vld_i;
  logic              tlb_flush_grant_o;
`ifdef RVH_MMU_MISS_ARB_PERF_EN
  logic [NP*32-1:0]  perf_grant_cnt_o;
  logic [31:0]       perf_stall_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rvh_mmu_miss_arb #(
    .NUM_PORTS(NP),
    .MAX_INFLIGHT(MI),
    .TRANS_ID_WIDTH(TW),
    .VPN_WIDTH(VW),
    .PAGE_LVL_WIDTH(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .miss_req_vld_i(miss_req_vld_i),
    .miss_req_trans_id_i(miss_req_trans_id_i),
    .miss_req_asid_i(miss_req_asid_i),
    .miss_req_vpn_i(miss_req_vpn_i),
    .miss_req_access_type_i(miss_req_access_type_i),
    .miss_req_rdy_o(miss_req_rdy_o),
    .miss_resp_vld_o(miss_resp_vld_o),
    .miss_resp_trans_id_o(miss_resp_trans_id_o),
    .miss_resp_asid_o(miss_resp_asid_o),
    .miss_resp_pte_o(miss_resp_pte_o),
    .miss_resp_page_lvl_o(miss_resp_page_lvl_o),
    .miss_resp_vpn_o(miss_resp_vpn_o),
    .miss_resp_access_type_o(miss_resp_access_type_o),
    .miss_resp_access_fault_o(miss_resp_access_fault_o),
    .miss_resp_page_fault_o(miss_resp_page_fault_o),
    .translate_req_vld_o(translate_req_vld_o),
    .translate_req_trans_id_o(translate_req_trans_id_o),
    .translate_req_asid_o(translate_req_asid_o),
    .translate_req_vpn_o(translate_req_vpn_o),
    .translate_req_access_type_o(translate_req_access_type_o),
    .translate_req_rdy_i(translate_req_rdy_i),
    .translate_resp_vld_i(translate_resp_vld_i),
    .translate_resp_trans_id_i(translate_resp_trans_id_i),
    .translate_resp_asid_i(translate_resp_asid_i),
    .translate_resp_pte_i(translate_resp_pte_i),
    .translate_resp_page_lvl_i(translate_resp_page_lvl_i),
    .translate_resp_vpn_i(translate_resp_vpn_i),
    .translate_resp_access_type_i(translate_resp_access_type_i),
    .translate_resp_access_fault_i(translate_resp_access_fault_i),
    .translate_resp_page_fault_i(translate_resp_page_fault_i),
    .tlb_flush_vld_i(tlb_flush_vld_i),
    .tlb_flush_grant_o(tlb_flush_grant_o)
`ifdef RVH_MMU_MISS_ARB_PERF_EN
    ,
    .perf_grant_cnt_o(perf_grant_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    miss_req_vld_i = '0;
    translate_req_rdy_i = 1'b0;
    translate_resp_vld_i = 1'b0;
    tlb_flush_vld_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle: drive, check mid-cycle, step past the next edge.
  task automatic cyc(input string tag,
                     input logic [2:0] vld,
                     input logic prdy,
                     input logic rsp,
                     input logic fl,
                     input logic [2:0] e_rdy,
                     input logic [2:0] e_rsp,
                     input logic e_fg,
                     input logic e_tv);
    miss_req_vld_i = vld;
    translate_req_rdy_i = prdy;
    translate_resp_vld_i = rsp;
    tlb_flush_vld_i = fl;
    @(negedge clk);
    check({tag, ".rdy"}, 64'(miss_req_rdy_o), 64'(e_rdy));
    check({tag, ".rsp"}, 64'(miss_resp_vld_o), 64'(e_rsp));
    check({tag, ".fgnt"}, 64'(tlb_flush_grant_o), 64'(e_fg));
    check({tag, ".tvld"}, 64'(translate_req_vld_o), 64'(e_tv));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    miss_req_vld_i = '0;
    miss_req_trans_id_i = {3'd3, 3'd2, 3'd1};
    miss_req_asid_i = '0;
    miss_req_vpn_i = '0;
    miss_req_access_type_i = '0;
    translate_req_rdy_i = 1'b0;
    translate_resp_vld_i = 1'b0;
    translate_resp_trans_id_i = '0;
    translate_resp_asid_i = '0;
    translate_resp_pte_i = '0;
    translate_resp_page_lvl_i = '0;
    translate_resp_vpn_i = '0;
    translate_resp_access_type_i = '0;
    translate_resp_access_fault_i = 1'b0;
    translate_resp_page_fault_i = 1'b0;
    tlb_flush_vld_i = 1'b0;
    #1;
    check("rst.tvld", 64'(translate_req_vld_o), 64'd0);
    check("rst.rdy", 64'(miss_req_rdy_o), 64'd0);
    check("rst.rsp", 64'(miss_resp_vld_o), 64'd0);
    check("rst.fgnt", 64'(tlb_flush_grant_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Ports 0 and 2 alternate.
    cyc("t1a0", 3'b101, 1, 0, 0, 3'b001, 3'b000, 0, 1);
    cyc("t1a1", 3'b101, 1, 1, 0, 3'b100, 3'b001, 0, 1);
    cyc("t1a2", 3'b101, 1, 1, 0, 3'b001, 3'b100, 0, 1);
    cyc("t1a3", 3'b101, 1, 1, 0, 3'b100, 3'b001, 0, 1);
    cyc("t1a4", 3'b000, 1, 1, 0, 3'b000, 3'b100, 0, 0);

    // Port 1 joins at cycle 2.
    do_reset();
    cyc("t1b0", 3'b101, 1, 0, 0, 3'b001, 3'b000, 0, 1);
    cyc("t1b1", 3'b101, 1, 1, 0, 3'b100, 3'b001, 0, 1);
    cyc("t1b2", 3'b111, 1, 1, 0, 3'b001, 3'b100, 0, 1);
    cyc("t1b3", 3'b111, 1, 1, 0, 3'b010, 3'b001, 0, 1);
    cyc("t1b4", 3'b111, 1, 1, 0, 3'b100, 3'b010, 0, 1);
    cyc("t1b5", 3'b000, 1, 1, 0, 3'b000, 3'b100, 0, 0);

    // Two in flight fill the FIFO; full blocks even with a pop.
    do_reset();
    cyc("t2c0", 3'b001, 1, 0, 0, 3'b001, 3'b000, 0, 1);
    cyc("t2c1", 3'b010, 1, 0, 0, 3'b010, 3'b000, 0, 1);
    cyc("t2c2", 3'b100, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    cyc("t2c3", 3'b100, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    cyc("t2c4", 3'b100, 1, 1, 0, 3'b000, 3'b001, 0, 0);
    cyc("t2c5", 3'b100, 1, 1, 0, 3'b100, 3'b010, 0, 1);
    cyc("t2c6", 3'b000, 1, 1, 0, 3'b000, 3'b100, 0, 0);

    // Payload through both directions.
    do_reset();
    miss_req_trans_id_i = {3'd0, 3'd5, 3'd0};
    miss_req_vpn_i = '0;
    miss_req_vpn_i[VW +: VW] = 27'h1234;
    miss_req_asid_i = '0;
    miss_req_asid_i[16 +: 16] = 16'h00ab;
    miss_req_access_type_i = 6'b00_01_00;
    miss_req_vld_i = 3'b010;
    translate_req_rdy_i = 1'b1;
    @(negedge clk);
    check("t3.rdy", 64'(miss_req_rdy_o), 64'b010);
    check("t3.qtid", 64'(translate_req_trans_id_o), 64'd5);
    check("t3.qvpn", 64'(translate_req_vpn_o), 64'h1234);
    check("t3.qasid", 64'(translate_req_asid_o), 64'h00ab);
    check("t3.qat", 64'(translate_req_access_type_o), 64'd1);
    @(posedge clk);
    #1;
    miss_req_vld_i = '0;
    translate_resp_vld_i = 1'b1;
    translate_resp_trans_id_i = 3'd5;
    translate_resp_vpn_i = 27'h1234;
    translate_resp_asid_i = 16'h00ab;
    translate_resp_pte_i = 64'hdead_beef_0000_1c01;
    translate_resp_page_lvl_i = 2'd1;
    translate_resp_access_type_i = 2'd1;
    translate_resp_page_fault_i = 1'b1;
    @(negedge clk);
    check("t3.rsp", 64'(miss_resp_vld_o), 64'b010);
    check("t3.rtid", 64'(miss_resp_trans_id_o), 64'd5);
    check("t3.rvpn", 64'(miss_resp_vpn_o), 64'h1234);
    check("t3.rpte", miss_resp_pte_o, 64'hdead_beef_0000_1c01);
    check("t3.rlvl", 64'(miss_resp_page_lvl_o), 64'd1);
    check("t3.rpf", 64'(miss_resp_page_fault_o), 64'd1);
    check("t3.raf", 64'(miss_resp_access_fault_o), 64'd0);
    @(posedge clk);
    #1;
    translate_resp_vld_i = 1'b0;

    // Flush with one in flight.
    do_reset();
    cyc("t4c0", 3'b001, 1, 0, 0, 3'b001, 3'b000, 0, 1);
    cyc("t4c1", 3'b000, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    cyc("t4c2", 3'b010, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    cyc("t4c3", 3'b010, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    cyc("t4c4", 3'b010, 1, 1, 1, 3'b000, 3'b001, 0, 0);
    cyc("t4c5", 3'b010, 1, 0, 1, 3'b000, 3'b000, 1, 0);
    cyc("t4c6", 3'b010, 1, 0, 0, 3'b010, 3'b000, 0, 1);
    cyc("t4c7", 3'b000, 1, 1, 0, 3'b000, 3'b010, 0, 0);

    // Flush with nothing in flight, dropped before the grant.
    cyc("t4e0", 3'b000, 1, 0, 1, 3'b000, 3'b000, 0, 0);
    cyc("t4e1", 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 0);
    cyc("t4e2", 3'b000, 1, 0, 0, 3'b000, 3'b000, 1, 0);
    cyc("t4e3", 3'b000, 1, 0, 0, 3'b000, 3'b000, 0, 0);

    // Reset in the middle of two walks.
    do_reset();
    cyc("t5c0", 3'b001, 1, 0, 0, 3'b001, 3'b000, 0, 1);
    cyc("t5c1", 3'b010, 1, 0, 0, 3'b010, 3'b000, 0, 1);
    miss_req_vld_i = 3'b100;
    translate_resp_vld_i = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t5.tvld", 64'(translate_req_vld_o), 64'd0);
    check("t5.rdy", 64'(miss_req_rdy_o), 64'd0);
    check("t5.rsp", 64'(miss_resp_vld_o), 64'd0);
    check("t5.fgnt", 64'(tlb_flush_grant_o), 64'd0);
    check("t5.qvpn", 64'(translate_req_vpn_o), 64'd0);
    check("t5.rpte", miss_resp_pte_o, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("t5p0", 3'b000, 1, 1, 0, 3'b000, 3'b000, 0, 0);
    cyc("t5p1", 3'b001, 1, 0, 0, 3'b001, 3'b000, 0, 1);

`ifdef RVH_MMU_MISS_ARB_PERF_EN
    do_reset();
    cyc("t6g0", 3'b001, 1, 0, 0, 3'b001, 3'b000, 0, 1);
    for (int i = 1; i < 10; i++)
      cyc("t6g", 3'b001, 1, 1, 0, 3'b001, 3'b001, 0, 1);
    cyc("t6s0", 3'b001, 0, 1, 0, 3'b000, 3'b001, 0, 1);
    for (int i = 1; i < 4; i++)
      cyc("t6s", 3'b001, 0, 0, 0, 3'b000, 3'b000, 0, 1);
    miss_req_vld_i = '0;
    @(negedge clk);
    check("t6.gnt0", 64'(perf_grant_cnt_o[31:0]), 64'd10);
    check("t6.gnt1", 64'(perf_grant_cnt_o[63:32]), 64'd0);
    check("t6.gnt2", 64'(perf_grant_cnt_o[95:64]), 64'd0);
    check("t6.stall", 64'(perf_stall_cnt_o), 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
